// File: rtl/rsa_pkg.sv
// Shared RSA parameters and modexp controller state encoding.
// Common to the exponentiation controller and the Montgomery multiplier.
package rsa_pkg;

    localparam int DEF_BITLEN  = 1024;
    localparam int DEF_BETALEN = 1;
    localparam int DEF_EXPW    = 11;
    localparam int NW_W        = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE_X,
        ST_PRE_A,
        ST_SQR,
        ST_MUL,
        ST_POST,
        ST_FIN
    } state_t;

endpackage

// File: rtl/mod_exp_ctrl_if.sv
// Request/response bus between the modexp controller and
// an external Montgomery multiplier.
interface mod_exp_ctrl_if
    import rsa_pkg::*;
#(
    parameter int BITLEN  = DEF_BITLEN,
    parameter int BETALEN = DEF_BETALEN
);

    logic                      mp_start;
    logic [BITLEN-1:0]         mp_a;
    logic [BITLEN-1:0]         mp_b;
    logic [BITLEN-1:0]         mp_m;
    logic [NW_W-1:0]           mp_num_words;
    logic                      mp_done;
    logic [BITLEN+BETALEN-1:0] mp_p;

    modport master (
        output mp_start,
        output mp_a,
        output mp_b,
        output mp_m,
        output mp_num_words,
        input  mp_done,
        input  mp_p
    );

    modport slave (
        input  mp_start,
        input  mp_a,
        input  mp_b,
        input  mp_m,
        input  mp_num_words,
        output mp_done,
        output mp_p
    );

endinterface

// File: rtl/cond_sub.sv
// Final reduction of a Montgomery product known to be below 2M.
// Returns p - m when p >= m, else p truncated to BITLEN.
module cond_sub
    import rsa_pkg::*;
#(
    parameter int BITLEN  = DEF_BITLEN,
    parameter int BETALEN = DEF_BETALEN
) (
    input  logic [BITLEN+BETALEN-1:0] p,
    input  logic [BITLEN-1:0]         m,
    output logic [BITLEN-1:0]         r
);

    localparam int PW = BITLEN + BETALEN;

    logic [PW-1:0]     mx;
    logic [BITLEN-1:0] d;

    assign mx = PW'(m);
    // p < 2M, so the difference always fits in BITLEN bits
    assign d  = p[BITLEN-1:0] - m;
    assign r  = (p >= mx) ? d : p[BITLEN-1:0];

endmodule

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply controller for X^E mod M
// in the Montgomery domain, driving an external multiplier.
module mod_exp_ctrl
    import rsa_pkg::*;
#(
    parameter int BITLEN  = DEF_BITLEN,
    parameter int BETALEN = DEF_BETALEN,
    parameter int EXPW    = DEF_EXPW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [BITLEN-1:0] base,
    input  logic [BITLEN-1:0] modulus,
    input  logic [BITLEN-1:0] r2,
    input  logic [BITLEN-1:0] r_mod,
    input  logic [BITLEN-1:0] exponent,
    input  logic [EXPW-1:0]   exp_len,
    input  logic [NW_W-1:0]   num_words,
    output logic              busy,
    output logic              done,
    output logic [BITLEN-1:0] result,
    mod_exp_ctrl_if.master    mp
);

    state_t state_q, state_d, after;
    logic   wait_q, wait_d;
    logic   ign_q, ign_d;

    logic [BITLEN-1:0] base_q, mod_q, r2_q, rmod_q, exp_q;
    logic [BITLEN-1:0] acc_q, xbar_q, result_q, esh, sub_r;
    logic [EXPW-1:0]   len_q, bit_q;
    logic [NW_W-1:0]   nw_q;
    logic              done_q;

    logic accept, cap, ebit, last_bit, is_prod;

    assign accept   = (state_q == ST_IDLE) && start && !done_q;
    assign cap      = wait_q && !ign_q && mp.mp_done;
    assign esh      = exp_q >> bit_q;
    assign ebit     = esh[0];
    assign last_bit = (bit_q == '0);
    assign is_prod  = (state_q == ST_PRE_X) || (state_q == ST_SQR)
                   || (state_q == ST_MUL)   || (state_q == ST_POST);

    cond_sub #(
        .BITLEN  (BITLEN),
        .BETALEN (BETALEN)
    ) u_cond_sub (
        .p (mp.mp_p),
        .m (mod_q),
        .r (sub_r)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            wait_q  <= 1'b0;
            ign_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            ign_q   <= ign_d;
        end
    end

    // Each product: issue cycle, one ignored cycle, then wait for done
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        ign_d   = ign_q;
        after   = ST_FIN;
        unique case (1'b1)
            (state_q == ST_PRE_X): after = ST_PRE_A;
            (state_q == ST_SQR):
                after = ebit ? ST_MUL : (last_bit ? ST_POST : ST_SQR);
            (state_q == ST_MUL):
                after = last_bit ? ST_POST : ST_SQR;
            default: after = ST_FIN;
        endcase
        unique case (state_q)
            ST_IDLE:  if (accept) state_d = ST_PRE_X;
            ST_PRE_A: state_d = (len_q == '0) ? ST_POST : ST_SQR;
            ST_FIN:   state_d = ST_IDLE;
            default: begin
                if (!wait_q) begin
                    wait_d = 1'b1;
                    ign_d  = 1'b1;
                end else if (ign_q) begin
                    ign_d = 1'b0;
                end else if (mp.mp_done) begin
                    wait_d  = 1'b0;
                    state_d = after;
                end
            end
        endcase
    end

    always_comb begin
        busy        = (state_q != ST_IDLE);
        mp.mp_start = is_prod && !wait_q;
        mp.mp_a     = acc_q;
        mp.mp_b     = acc_q;
        unique case (1'b1)
            (state_q == ST_PRE_X): begin
                mp.mp_a = base_q;
                mp.mp_b = r2_q;
            end
            (state_q == ST_MUL):  mp.mp_b = xbar_q;
            (state_q == ST_POST): mp.mp_b = BITLEN'(1);
            default: ;
        endcase
    end

    assign mp.mp_m         = mod_q;
    assign mp.mp_num_words = nw_q;
    assign done            = done_q;
    assign result          = result_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            base_q   <= '0;
            mod_q    <= '0;
            r2_q     <= '0;
            rmod_q   <= '0;
            exp_q    <= '0;
            len_q    <= '0;
            nw_q     <= '0;
            acc_q    <= '0;
            xbar_q   <= '0;
            result_q <= '0;
            bit_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= (state_q == ST_FIN);
            if (accept) begin
                base_q <= base;
                mod_q  <= modulus;
                r2_q   <= r2;
                rmod_q <= r_mod;
                exp_q  <= exponent;
                len_q  <= exp_len;
                nw_q   <= num_words;
            end
            if (state_q == ST_PRE_A) begin
                acc_q <= rmod_q;
                bit_q <= len_q - EXPW'(1);
            end
            if (cap) begin
                if (state_q == ST_PRE_X) xbar_q <= sub_r;
                else                     acc_q  <= sub_r;
                if (!last_bit && ((state_q == ST_SQR && !ebit)
                                  || state_q == ST_MUL))
                    bit_q <= bit_q - EXPW'(1);
            end
            if (state_q == ST_FIN) result_q <= acc_q;
        end
    end

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Bench for mod_exp_ctrl: M=13, R=256, random-latency Montgomery
// responder and a plain modular-power reference.
module tb_mod_exp_ctrl;

    localparam int BL   = 8;
    localparam int BB   = 1;
    localparam int EW   = 11;
    localparam int M    = 13;
    // 256 * 3 = 768 = 59*13 + 1
    localparam int RINV = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [BL-1:0] base = '0, modulus = '0, r2 = '0;
    logic [BL-1:0] r_mod = '0, exponent = '0;
    logic [EW-1:0] exp_len = '0;
    logic [9:0]    num_words = '0;
    logic          busy, done;
    logic [BL-1:0] result;

    int total = 0;
    int bad   = 0;
    bit hold_mode = 1'b0;
    bit plus_m    = 1'b0;
    bit rand_plus = 1'b1;

    mod_exp_ctrl_if #(.BITLEN(BL), .BETALEN(BB)) mp ();

    mod_exp_ctrl #(.BITLEN(BL), .BETALEN(BB), .EXPW(EW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base      (base),
        .modulus   (modulus),
        .r2        (r2),
        .r_mod     (r_mod),
        .exponent  (exponent),
        .exp_len   (exp_len),
        .num_words (num_words),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .mp        (mp)
    );

    always #5 clk = ~clk;

    function automatic int mp_ref(int a, int b);
        return (a * b * RINV) % M;
    endfunction

    function automatic int emask(int e, int len);
        return (len >= BL) ? (e & 255) : (e & ((1 << len) - 1));
    endfunction

    function automatic int ref_pow(int b, int e, int len);
        int r;
        r = 1 % M;
        for (int k = 0; k < emask(e, len); k++) r = (r * (b % M)) % M;
        return r;
    endfunction

    function automatic int ref_np(int e, int len);
        return 2 + len + $countones(emask(e, len));
    endfunction

    function automatic logic [8:0] junk(logic [8:0] v);
        return 9'(((int'(v) % M) + 1) % M);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Multiplier stand-in; mp_p is wrong outside its valid window
    initial begin : responder
        int         cnt;
        logic [8:0] pv;
        cnt = -1;
        pv  = '0;
        mp.mp_done = 1'b0;
        mp.mp_p    = '0;
        forever begin
            @(negedge clk);
            if (mp.mp_start === 1'b1) begin
                pv = 9'(mp_ref(int'(mp.mp_a), int'(mp.mp_b)));
                if (plus_m || (rand_plus && $urandom_range(0, 1) == 1))
                    pv = pv + 9'(M);
                cnt = hold_mode ? 2 : int'($urandom_range(3, 20));
                mp.mp_done = hold_mode;
                mp.mp_p    = junk(pv);
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    mp.mp_done = 1'b1;
                    mp.mp_p    = pv;
                end else begin
                    mp.mp_p = junk(pv);
                end
            end else if (cnt == 0 && hold_mode) begin
                cnt     = -1;
                mp.mp_p = junk(pv);
            end
        end
    end

    task automatic load(input int b, input int e, input int len,
                        input logic [9:0] nw);
        base      = BL'(b);
        exponent  = BL'(e);
        exp_len   = EW'(len);
        modulus   = BL'(M);
        r2        = 8'd3;
        r_mod     = 8'd9;
        num_words = nw;
    endtask

    task automatic scramble();
        base      = BL'($urandom);
        exponent  = BL'($urandom);
        exp_len   = EW'($urandom_range(0, 8));
        modulus   = BL'($urandom);
        r2        = BL'($urandom);
        r_mod     = BL'($urandom);
        num_words = 10'($urandom);
    endtask

    task automatic run_chk(input string tag, input int b, input int e,
                           input int len, input int restart_at,
                           input bit start_on_done);
        int            np, nd, bh;
        bit            got;
        logic [BL-1:0] res;
        logic [9:0]    nw;
        int            st[$];
        @(negedge clk);
        nw = 10'($urandom_range(1, 1023));
        load(b, e, len, nw);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        scramble();
        chk({tag, "_busy"}, busy, 1);
        np  = 0;
        got = 1'b0;
        res = '0;
        for (int cyc = 0; cyc < 3000 && !got; cyc++) begin
            start = (cyc == restart_at);
            if (mp.mp_start === 1'b1) begin
                if (np == 0) begin
                    chk({tag, "_nw"}, mp.mp_num_words, nw);
                    chk({tag, "_m"}, mp.mp_m, M);
                end
                np++;
                st.push_back(cyc);
            end
            if (done === 1'b1) begin
                got   = 1'b1;
                res   = result;
                start = start_on_done;
            end else begin
                @(negedge clk);
            end
        end
        chk({tag, "_done_seen"}, got, 1);
        chk({tag, "_result"}, res, ref_pow(b, e, len));
        chk({tag, "_nprod"}, np, ref_np(e, len));
        if (hold_mode)
            for (int i = 1; i < st.size(); i++)
                chk({tag, "_gap"}, st[i] - st[i-1], (i == 1) ? 4 : 3);
        nd = 0;
        bh = 0;
        repeat (6) begin
            @(negedge clk);
            start = 1'b0;
            if (done === 1'b1) nd++;
            if (busy !== 1'b0) bh++;
        end
        chk({tag, "_extra_done"}, nd, 0);
        chk({tag, "_idle_busy"}, bh, 0);
        chk({tag, "_held"}, result, ref_pow(b, e, len));
    endtask

    initial begin : main
        int np, nd, ns;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mp_start", mp.mp_start, 0);
        chk("rst_result", result, 0);
        rst_n = 1'b1;

        run_chk("r37", 4, 5, 3, -1, 1'b0);
        run_chk("r38", 2, int'($urandom_range(0, 255)), 0, -1, 1'b0);
        rand_plus = 1'b0;
        plus_m    = 1'b1;
        run_chk("r39", 12, 2, 2, -1, 1'b0);
        plus_m    = 1'b0;
        rand_plus = 1'b1;
        run_chk("r40", 7, 1, 1, 5, 1'b0);

        // abandon a run while its third product is outstanding
        @(negedge clk);
        load(4, 5, 3, 10'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        np = 0;
        for (int cyc = 0; cyc < 2000 && np < 3; cyc++) begin
            if (mp.mp_start === 1'b1) np++;
            if (np < 3) @(negedge clk);
        end
        chk("r41_third", np, 3);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("r41_busy", busy, 0);
        chk("r41_mp_start", mp.mp_start, 0);
        chk("r41_done", done, 0);
        chk("r41_result", result, 0);
        rst_n = 1'b1;
        nd = 0;
        ns = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) nd++;
            if (mp.mp_start === 1'b1) ns++;
        end
        chk("r41_no_done", nd, 0);
        chk("r41_no_mps", ns, 0);
        run_chk("r41_after", 4, 5, 3, -1, 1'b0);

        hold_mode = 1'b1;
        run_chk("r42a", 4, 5, 3, -1, 1'b0);
        run_chk("r42b", int'($urandom_range(0, 255)),
                int'($urandom_range(0, 255)), 8, -1, 1'b0);
        hold_mode = 1'b0;

        run_chk("r29", 3, 6, 3, -1, 1'b1);

        for (int k = 0; k < 6; k++)
            run_chk("rnd", int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 8)), -1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
